dma_io_channel_device: RTL and testbench
========================================

// Module: dma_io_channel_device
// PURPOSE
// - Peripheral on one 8237A DMA channel; plugs into the IODevice side of the system bus.
// - Raises dreq and answers dack plus nIOR/nIOW strobes on the shared 8-bit Data bus.
// - Buffers bytes in a TX FIFO (device->memory) and an RX FIFO (memory->device).
// - Local side is a valid/ready byte stream for the device model or the testbench.
// PARAMETERS
// - FIFO_DEPTH  8  entries per FIFO; power of 2, >=2
// - DREQ_MIN    1  TX bytes held (dir=0) or RX free slots (dir=1) needed to raise dreq; 1..FIFO_DEPTH
// PORTS
// - Clock        in     1  system clock; sole clock
// - Reset        in     1  synchronous, active-high
// - dack         in     1  this channel's DMA acknowledge, active-high
// - nIOR         in     1  I/O read strobe, active-low (device drives Data)
// - nIOW         in     1  I/O write strobe, active-low (device samples Data)
// - Data         inout  8  system data bus, tri-stated when not driving
// - dreq         out    1  DMA request, registered
// - dir          in     1  0 = device->memory (TX), 1 = memory->device (RX); change only in IDLE
// - tx_valid     in     1  local byte offered to TX FIFO
// - tx_data      in     8  local byte
// - tx_ready     out    1  TX FIFO not full
// - rx_valid     out    1  RX FIFO not empty
// - rx_data      out    8  RX FIFO head, valid when rx_valid
// - rx_ready     in     1  local consumer pops RX head
// - err_dir      out    1  sticky: strobe opposite to dir during ACK
// - err_overrun  out    1  sticky: nIOW commit while RX full (byte dropped)
// BEHAVIOUR
// - Reset: both FIFOs empty; FSM=IDLE; dreq=0; Data=Z; tx_ready=1; rx_valid=0; err_*=0; rx_data=8'h00.
//   Reset mid-transfer aborts at once: contents discarded, Data released that cycle.
// - FIFOs: registered pointers, count width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//   Local push/pop fire on valid&ready at a rising Clock edge.
//   Same-cycle local push and bus pop (TX), or bus push and local pop (RX), are legal; count stays unchanged.
// - req_ok: dir=0 -> tx_count>=DREQ_MIN; dir=1 -> (FIFO_DEPTH-rx_count)>=DREQ_MIN.
// - FSM, one state-transition evaluation per Clock:
//   - IDLE: if req_ok -> REQ (dreq=1 from next cycle).
//   - REQ: dack=1 -> ACK; req_ok lost -> IDLE (dreq=0).
//   - ACK: hold dreq=1; watch strobes; dack drops -> IDLE (dreq=0 next cycle).
//     After a commit: stay in ACK while req_ok still holds (post-commit counts);
//     otherwise -> IDLE with dreq=0 next cycle.
// - TX read (dir=0, ACK, dack=1, nIOR=0): Data driven combinationally with TX head.
//   Commit = pop on nIOR rising edge (nIOR_q=0 & nIOR=1 & dack=1). Data goes Z in the same cycle nIOR rises.
// - RX write (dir=1, ACK, dack=1, nIOW=0): Data captured into a holding register every low cycle.
//   Commit = push of the holding register on nIOW rising edge. If RX full: byte dropped, err_overrun set.
// - Wrong-direction strobe in ACK: no drive, no FIFO change, err_dir set.
// - Strobes while dack=0, or outside ACK: ignored; Data never driven.
// - Empty TX in ACK (cannot occur while req_ok holds): drive 8'hFF, no pop.
// - Exactly one commit per strobe low pulse, however long the pulse.
// - Latency: req_ok true -> dreq=1 after 2 Clock edges; commit -> count update 1 edge later.
// - err_* clear only on Reset.
// TESTING
// - Push 3 bytes A1,A2,A3 with dir=0, DREQ_MIN=1; dack=1 plus three 2-cycle nIOR pulses
//   -> Data reads A1,A2,A3; dreq falls after 3rd commit; tx_ready stays 1.
// - dir=1: four nIOW pulses with 10,20,30,40 -> rx_data pops 10,20,30,40 in order; err_overrun=0.
// - dir=1, FIFO_DEPTH=8, rx_ready=0: 9 nIOW pulses
//   -> dreq drops after 8th commit; 9th forced pulse sets err_overrun; rx_count=8.
// - dir=0, dack=1, single nIOW pulse -> err_dir=1, Data stays Z, tx_count unchanged.
// - Reset asserted mid-nIOR pulse with 5 bytes queued
//   -> next cycle Data=Z, dreq=0, tx_count=0, FSM=IDLE.
// - DREQ_MIN=4, push 3 then 1 byte (dir=0) -> dreq stays 0 until 4th push, then 1 two edges later.

Source files
------------

// File: rtl/dma_io_channel_device_if.sv
// Local byte-stream side of the DMA I/O channel device (device model <-> channel FIFOs).
// Handshake: a byte moves on a rising clock edge where valid & ready are both high;
// valid never waits on ready, and data is held stable for as long as valid is high.
interface dma_io_channel_device_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport slave  (input  tx_valid, tx_data, rx_ready, output tx_ready, rx_valid, rx_data);
  modport master (output tx_valid, tx_data, rx_ready, input  tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/dma_io_channel_device.sv
// Peripheral on one 8237A DMA channel: TX/RX byte FIFOs between a local stream and the
// shared 8-bit I/O bus, with a dreq/dack request FSM and strobe-edge commits.
module dma_io_channel_device #(
  parameter int FIFO_DEPTH = 8,
  parameter int DREQ_MIN   = 1
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        dack,
  input  logic                        nIOR,
  input  logic                        nIOW,
  inout  wire  [7:0]                  Data,
  output logic                        dreq,
  input  logic                        dir,
  dma_io_channel_device_if.slave      loc,
  output logic                        err_dir,
  output logic                        err_overrun,
  output logic [1:0]                  dbg_state,
  output logic [$clog2(FIFO_DEPTH):0] dbg_tx_count,
  output logic [$clog2(FIFO_DEPTH):0] dbg_rx_count,
  output logic                        dbg_data_oe
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MIN_C   = CW'(DREQ_MIN);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  logic [1:0]    state, state_nx;
  logic          nior_q, niow_q;
  logic [7:0]    hold_q;
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [CW-1:0] tx_count, rx_count, tx_count_nx, rx_count_nx;
  logic          in_ack, rx_full, tx_push, tx_pop, rx_push, rx_pop;
  logic          niow_rise, ovr_set, dir_set, req_ok, req_ok_nx;
  logic [7:0]    tx_head;

  assign in_ack    = (state == ST_ACK) && dack;
  assign rx_full   = (rx_count == DEPTH_C);
  assign tx_push   = loc.tx_valid && loc.tx_ready;
  assign tx_pop    = in_ack && !dir && !nior_q && nIOR && (tx_count != '0);
  assign rx_pop    = loc.rx_valid && loc.rx_ready;
  // A write strobe that rises into a full RX FIFO is an overrun whatever the FSM state,
  // since the controller still believes it delivered that byte.
  assign niow_rise = dack && dir && !niow_q && nIOW;
  assign rx_push   = niow_rise && (state == ST_ACK) && !rx_full;
  assign ovr_set   = niow_rise && rx_full;
  assign dir_set   = in_ack && (dir ? !nIOR : !nIOW);

  assign tx_count_nx = tx_count + CW'(tx_push) - CW'(tx_pop);
  assign rx_count_nx = rx_count + CW'(rx_push) - CW'(rx_pop);
  assign req_ok      = dir ? ((DEPTH_C - rx_count) >= MIN_C) : (tx_count >= MIN_C);
  assign req_ok_nx   = dir ? ((DEPTH_C - rx_count_nx) >= MIN_C) : (tx_count_nx >= MIN_C);

  assign tx_head     = (tx_count != '0) ? tx_mem[tx_rptr] : 8'hFF;
  assign dbg_data_oe = in_ack && !dir && !nIOR && !Reset;
  assign Data        = dbg_data_oe ? tx_head : 8'hzz;

  assign loc.tx_ready = (tx_count != DEPTH_C);
  assign loc.rx_valid = (rx_count != '0);
  assign loc.rx_data  = loc.rx_valid ? rx_mem[rx_rptr] : 8'h00;

  assign dbg_state    = state;
  assign dbg_tx_count = tx_count;
  assign dbg_rx_count = rx_count;

  // ACK decides on post-commit counts so dreq drops the cycle after the last transfer.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (req_ok) state_nx = ST_REQ;
      ST_REQ: begin
        if (dack)         state_nx = ST_ACK;
        else if (!req_ok) state_nx = ST_IDLE;
      end
      ST_ACK:  if (!dack || !req_ok_nx) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= ST_IDLE;
      dreq        <= 1'b0;
      nior_q      <= 1'b1;
      niow_q      <= 1'b1;
      hold_q      <= 8'h00;
      tx_wptr     <= '0;
      tx_rptr     <= '0;
      rx_wptr     <= '0;
      rx_rptr     <= '0;
      tx_count    <= '0;
      rx_count    <= '0;
      err_dir     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state    <= state_nx;
      dreq     <= (state_nx != ST_IDLE);
      nior_q   <= nIOR;
      niow_q   <= nIOW;
      tx_count <= tx_count_nx;
      rx_count <= rx_count_nx;
      if (in_ack && dir && !nIOW) hold_q <= Data;
      if (tx_push) tx_wptr <= tx_wptr + AW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + AW'(1);
      if (rx_push) rx_wptr <= rx_wptr + AW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + AW'(1);
      if (dir_set) err_dir <= 1'b1;
      if (ovr_set) err_overrun <= 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (tx_push) tx_mem[tx_wptr] <= loc.tx_data;
    if (rx_push) rx_mem[rx_wptr] <= hold_q;
  end
endmodule

// File: tb/tb_dma_io_channel_device.sv
// Bench for dma_io_channel_device: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized TX/RX bursts.
module tb_dma_io_channel_device;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  // clock / reset / bus drive
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dack = 1'b0, nior = 1'b1, niow = 1'b1, dir = 1'b0;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_dval = 8'h00;
  wire  [7:0] data_a, data_b;
  logic       dreq_a, dreq_b, err_dir_a, err_ovr_a, err_dir_b, err_ovr_b, oe_a, oe_b;
  logic [1:0] st_a, st_b;
  logic [CW-1:0] txc_a, rxc_a, txc_b, rxc_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign data_a = tb_drv ? tb_dval : 8'hzz;

  dma_io_channel_device_if la ();
  dma_io_channel_device_if lb ();

  dma_io_channel_device #(.FIFO_DEPTH(DEPTH), .DREQ_MIN(1)) dut_a (
    .Clock(clk), .Reset(rst), .dack(dack), .nIOR(nior), .nIOW(niow), .Data(data_a),
    .dreq(dreq_a), .dir(dir), .loc(la), .err_dir(err_dir_a), .err_overrun(err_ovr_a),
    .dbg_state(st_a), .dbg_tx_count(txc_a), .dbg_rx_count(rxc_a), .dbg_data_oe(oe_a)
  );

  dma_io_channel_device #(.FIFO_DEPTH(DEPTH), .DREQ_MIN(4)) dut_b (
    .Clock(clk), .Reset(rst), .dack(1'b0), .nIOR(1'b1), .nIOW(1'b1), .Data(data_b),
    .dreq(dreq_b), .dir(1'b0), .loc(lb), .err_dir(err_dir_b), .err_overrun(err_ovr_b),
    .dbg_state(st_b), .dbg_tx_count(txc_b), .dbg_rx_count(rxc_b), .dbg_data_oe(oe_b)
  );

  // reference model: FIFO contents as queues, sticky flags, expected bus drive
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rd_log[$];
  logic       exp_err_dir = 1'b0, exp_err_ovr = 1'b0, exp_oe = 1'b0;
  logic       m_tx_commit = 1'b0, m_rx_commit = 1'b0, m_dir_strobe = 1'b0;
  logic [7:0] m_rx_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_p
    bit tx_can, rx_full_m, rx_has;
    tx_can    = tx_q.size() < DEPTH;
    rx_full_m = rx_q.size() == DEPTH;
    rx_has    = rx_q.size() > 0;
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      exp_err_dir = 1'b0;
      exp_err_ovr = 1'b0;
    end else begin
      if (m_tx_commit && tx_q.size() > 0) void'(tx_q.pop_front());
      if (la.tx_valid && tx_can) tx_q.push_back(la.tx_data);
      if (la.rx_ready && rx_has) void'(rx_q.pop_front());
      if (m_rx_commit) begin
        if (rx_full_m) exp_err_ovr = 1'b1;
        else           rx_q.push_back(m_rx_byte);
      end
      if (m_dir_strobe) exp_err_dir = 1'b1;
    end
  end

  // scoreboard compare, every cycle outside reset
  always @(negedge clk) begin
    if (!rst) begin
      chk("tx_count", 32'(txc_a), 32'(tx_q.size()));
      chk("rx_count", 32'(rxc_a), 32'(rx_q.size()));
      chk("tx_ready", 32'(la.tx_ready), 32'(tx_q.size() < DEPTH));
      chk("rx_valid", 32'(la.rx_valid), 32'(rx_q.size() > 0));
      if (rx_q.size() > 0) chk("rx_data", 32'(la.rx_data), 32'(rx_q[0]));
      chk("err_dir", 32'(err_dir_a), 32'(exp_err_dir));
      chk("err_overrun", 32'(err_ovr_a), 32'(exp_err_ovr));
      chk("data_oe", 32'(oe_a), 32'(exp_oe));
      if (exp_oe) chk("data_rd", 32'(data_a), 32'(tx_q.size() > 0 ? tx_q[0] : 8'hFF));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dack = 1'b0; nior = 1'b1; niow = 1'b1; tb_drv = 1'b0; exp_oe = 1'b0;
    m_tx_commit = 1'b0; m_rx_commit = 1'b0; m_dir_strobe = 1'b0;
    la.tx_valid = 1'b0; la.tx_data = 8'h00; la.rx_ready = 1'b0;
    lb.tx_valid = 1'b0; lb.tx_data = 8'h00; lb.rx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic push_a(input logic [7:0] b);
    la.tx_valid = 1'b1;
    la.tx_data  = b;
    tick();
    la.tx_valid = 1'b0;
  endtask

  task automatic grant(input string name);
    int n = 0;
    while (!dreq_a && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_dreq_wait"}, 32'(dreq_a), 32'd1);
    dack = 1'b1;
    tick();
  endtask

  // nIOR low for lo edges; any pending local push is dropped after the first edge
  task automatic ior_pulse(input int lo);
    nior = 1'b0;
    if (dir) m_dir_strobe = 1'b1;
    else     exp_oe = 1'b1;
    for (int i = 0; i < lo; i++) begin
      tick();
      la.tx_valid = 1'b0;
    end
    rd_log.push_back(data_a);
    nior = 1'b1; exp_oe = 1'b0; m_dir_strobe = 1'b0;
    if (!dir) m_tx_commit = 1'b1;
    tick();
    m_tx_commit = 1'b0;
  endtask

  task automatic iow_pulse(input int lo, input logic [7:0] v);
    niow = 1'b0; tb_drv = 1'b1; tb_dval = v;
    if (!dir) m_dir_strobe = 1'b1;
    repeat (lo) tick();
    niow = 1'b1; tb_drv = 1'b0; m_dir_strobe = 1'b0;
    if (dir) begin
      m_rx_commit = 1'b1;
      m_rx_byte   = v;
    end
    tick();
    m_rx_commit = 1'b0;
  endtask

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp_rd[3];
    logic [7:0] exp_rx[4];
    int guard;
    exp_rd = '{8'hA1, 8'hA2, 8'hA3};
    exp_rx = '{8'd10, 8'd20, 8'd30, 8'd40};

    // reset values
    dir = 1'b0;
    do_reset();
    chk("rst_dreq", 32'(dreq_a), 32'd0);
    chk("rst_tx_ready", 32'(la.tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(la.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(la.rx_data), 32'h00);
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_errs", 32'({err_dir_a, err_ovr_a}), 32'd0);

    // TX: three bytes read out over three 2-cycle nIOR pulses
    push_a(8'hA1); push_a(8'hA2); push_a(8'hA3);
    rd_log.delete();
    grant("tx3");
    for (int i = 0; i < 3; i++) ior_pulse(2);
    chk("tx3_dreq_fall", 32'(dreq_a), 32'd0);
    for (int i = 0; i < 3; i++) chk("tx3_read", 32'(rd_log[i]), 32'(exp_rd[i]));
    chk("tx3_count", 32'(txc_a), 32'd0);
    dack = 1'b0;

    // RX: four writes popped in order
    dir = 1'b1;
    do_reset();
    grant("rx4");
    for (int i = 0; i < 4; i++) iow_pulse(2, exp_rx[i]);
    dack = 1'b0;
    la.rx_ready = 1'b1;
    got.delete();
    guard = 0;
    while (la.rx_valid && guard < 10) begin
      got.push_back(la.rx_data);
      tick();
      guard++;
    end
    la.rx_ready = 1'b0;
    chk("rx4_n", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("rx4_pop", 32'(got[i]), 32'(exp_rx[i]));
    chk("rx4_ovr", 32'(err_ovr_a), 32'd0);

    // RX overrun: nine writes, consumer stalled
    do_reset();
    grant("ovr");
    for (int i = 0; i < 8; i++) iow_pulse(1, 8'(8'h50 + i));
    chk("ovr_dreq_fall", 32'(dreq_a), 32'd0);
    chk("ovr_count8", 32'(rxc_a), 32'd8);
    chk("ovr_before", 32'(err_ovr_a), 32'd0);
    iow_pulse(1, 8'h99);
    chk("ovr_set", 32'(err_ovr_a), 32'd1);
    chk("ovr_count_after", 32'(rxc_a), 32'd8);
    dack = 1'b0;

    // wrong-direction strobe
    dir = 1'b0;
    do_reset();
    push_a(8'h5A);
    grant("wdir");
    iow_pulse(2, 8'h33);
    chk("wdir_err", 32'(err_dir_a), 32'd1);
    chk("wdir_count", 32'(txc_a), 32'd1);
    chk("wdir_oe", 32'(oe_a), 32'd0);
    dack = 1'b0;

    // reset in the middle of an nIOR pulse
    do_reset();
    for (int i = 0; i < 5; i++) push_a(8'(8'hC0 + i));
    grant("rstmid");
    nior = 1'b0; exp_oe = 1'b1;
    tick();
    chk("rstmid_oe_before", 32'(oe_a), 32'd1);
    chk("rstmid_data", 32'(data_a), 32'hC0);
    rst = 1'b1; exp_oe = 1'b0;
    #1;
    chk("rstmid_oe_same", 32'(oe_a), 32'd0);
    tick();
    chk("rstmid_oe", 32'(oe_a), 32'd0);
    chk("rstmid_dreq", 32'(dreq_a), 32'd0);
    chk("rstmid_count", 32'(txc_a), 32'd0);
    chk("rstmid_state", 32'(st_a), 32'd0);
    nior = 1'b1; dack = 1'b0;
    rst = 1'b0;
    tick();

    // DREQ_MIN=4 threshold and latency
    do_reset();
    for (int i = 0; i < 3; i++) begin
      lb.tx_valid = 1'b1; lb.tx_data = 8'(i);
      tick();
    end
    lb.tx_valid = 1'b0;
    repeat (4) tick();
    chk("min4_below", 32'(dreq_b), 32'd0);
    chk("min4_count3", 32'(txc_b), 32'd3);
    lb.tx_valid = 1'b1; lb.tx_data = 8'h44;
    tick();
    lb.tx_valid = 1'b0;
    chk("min4_edge1", 32'(dreq_b), 32'd0);
    tick();
    chk("min4_edge2", 32'(dreq_b), 32'd1);

    // randomized TX bursts with occasional local pushes during reads
    for (int r = 0; r < 6; r++) begin
      dir = 1'b0;
      do_reset();
      for (int i = 0; i < $urandom_range(1, 8); i++) begin
        push_a(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) tick();
      end
      grant("rnd_tx");
      guard = 0;
      while (tx_q.size() > 0 && guard < 40) begin
        if (tx_q.size() < DEPTH - 1 && $urandom_range(0, 3) == 0) begin
          la.tx_valid = 1'b1;
          la.tx_data  = 8'($urandom_range(0, 255));
        end
        ior_pulse($urandom_range(1, 3));
        if (tx_q.size() > 0) repeat ($urandom_range(0, 2)) tick();
        guard++;
      end
      chk("rnd_tx_drained", 32'(tx_q.size()), 32'd0);
      chk("rnd_tx_dreq", 32'(dreq_a), 32'd0);
      dack = 1'b0;
    end

    // randomized RX bursts with a random local consumer
    for (int r = 0; r < 6; r++) begin
      dir = 1'b1;
      do_reset();
      grant("rnd_rx");
      for (int i = 0; i < $urandom_range(1, 6); i++) begin
        la.rx_ready = 1'($urandom_range(0, 1));
        iow_pulse($urandom_range(1, 3), 8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 1)) tick();
      end
      dack = 1'b0;
      la.rx_ready = 1'b1;
      guard = 0;
      while (rx_q.size() > 0 && guard < 20) begin
        tick();
        guard++;
      end
      la.rx_ready = 1'b0;
      chk("rnd_rx_drained", 32'(rx_q.size()), 32'd0);
      chk("rnd_rx_ovr", 32'(err_ovr_a), 32'd0);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
